mem_arbiter: RTL and testbench

Sequential arbiter that shares one single-ported, word-indexed 32-bit memory between the instruction-fetch port and the load/store port of the RISC-V core. It owns the memory's `addr`/`Din`/`we`/`re` pins. It converts byte addresses to word indices and rejects misaligned or out-of-range accesses without touching memory. It returns registered read data with a fixed one-cycle response.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_addr_check.sv | 15 +
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/load-store memory arbiter.
package mem_arb_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

endpackage

// File: rtl/mem_addr_check.sv
// Byte-to-word address conversion with alignment and range check; purely combinational.
module mem_addr_check #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DEPTH  = 256
) (
    input  logic [ADDR_W-1:0] byte_addr,
    output logic [ADDR_W-1:0] word_idx,
    output logic              err
);
    import mem_arb_pkg::*;

    assign word_idx = byte_addr >> WORD_SHIFT;
    assign err      = (byte_addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(DEPTH));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter for one single-ported word memory; grant is Moore,
// response pulses one cycle after the grant; requesters hold until their grant (no skid).
module mem_arbiter #(
    parameter int DATA_W = mem_arb_pkg::DATA_W,
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_out
);
    import mem_arb_pkg::*;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [ADDR_W-1:0]   word_idx;
    logic                chk_err;
    logic                is_store;
    logic                if_rvalid_q, if_err_q, d_ack_q, d_err_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;

    // The port just granted is masked for one cycle, giving alternation under contention.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req)       state_d = GNT_D;
                else if (if_req) state_d = GNT_I;
            end
            GNT_I:   state_d = d_req  ? GNT_D : IDLE;
            GNT_D:   state_d = if_req ? GNT_I : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign if_gnt   = (state_q == GNT_I);
    assign d_gnt    = (state_q == GNT_D);
    assign gnt_addr = d_gnt ? d_addr : if_addr;
    assign is_store = d_gnt && d_we;

    mem_addr_check #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_chk (
        .byte_addr (gnt_addr),
        .word_idx  (word_idx),
        .err       (chk_err)
    );

    // Memory pins are decoded from the registered state so reset drops mem_we immediately.
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        if ((if_gnt || d_gnt) && !chk_err) begin
            mem_addr = word_idx;
            if (is_store) begin
                mem_we  = 1'b1;
                mem_din = d_wdata;
            end else begin
                mem_re  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            if_rvalid_q <= if_gnt;
            d_ack_q     <= d_gnt;
            if (if_gnt) begin
                if_rdata_q <= chk_err ? '0 : mem_out;
                if_err_q   <= chk_err;
            end
            if (d_gnt) begin
                d_rdata_q <= (chk_err || d_we) ? '0 : mem_out;
                d_err_q   <= chk_err;
            end
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256-word memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_ack, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_din, mem_out;
    logic        mem_we, mem_re;

    logic [31:0] mem [0:255];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_out   (mem_out)
    );

    assign mem_out = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'd256) mem[mem_addr[7:0]] <= mem_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".if_gnt"},    {31'd0, if_gnt},    32'd0);
        chk({tag, ".d_gnt"},     {31'd0, d_gnt},     32'd0);
        chk({tag, ".if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
        chk({tag, ".d_ack"},     {31'd0, d_ack},     32'd0);
        chk({tag, ".if_err"},    {31'd0, if_err},    32'd0);
        chk({tag, ".d_err"},     {31'd0, d_err},     32'd0);
        chk({tag, ".if_rdata"},  if_rdata,           32'd0);
        chk({tag, ".d_rdata"},   d_rdata,            32'd0);
        chk({tag, ".mem_addr"},  mem_addr,           32'd0);
        chk({tag, ".mem_din"},   mem_din,            32'd0);
        chk({tag, ".mem_we"},    {31'd0, mem_we},    32'd0);
        chk({tag, ".mem_re"},    {31'd0, mem_re},    32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[5] = 32'h00A0_8023;
        mem[3] = 32'hDEAD_BEEF;

        // Reset state
        #12;
        all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch only from 0x14
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        chk("fetch.if_gnt",   {31'd0, if_gnt}, 32'd1);
        chk("fetch.d_gnt",    {31'd0, d_gnt},  32'd0);
        chk("fetch.mem_addr", mem_addr,        32'd5);
        chk("fetch.mem_re",   {31'd0, mem_re}, 32'd1);
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch.if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("fetch.if_rdata",  if_rdata,           32'h00A0_8023);
        chk("fetch.if_err",    {31'd0, if_err},    32'd0);
        chk("fetch.if_gnt_off",{31'd0, if_gnt},    32'd0);
        @(negedge clk);
        chk("fetch.rvalid_pulse", {31'd0, if_rvalid}, 32'd0);

        // Simultaneous fetch and load 0x0C: data wins from IDLE
        if_req = 1'b1; if_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0C;
        @(negedge clk);
        chk("both.d_gnt",    {31'd0, d_gnt},  32'd1);
        chk("both.if_gnt0",  {31'd0, if_gnt}, 32'd0);
        chk("both.mem_addr", mem_addr,        32'd3);
        chk("both.mem_re",   {31'd0, mem_re}, 32'd1);
        d_req = 1'b0;
        @(negedge clk);
        chk("both.if_gnt",  {31'd0, if_gnt}, 32'd1);
        chk("both.d_ack",   {31'd0, d_ack},  32'd1);
        chk("both.d_rdata", d_rdata,         32'hDEAD_BEEF);
        chk("both.d_err",   {31'd0, d_err},  32'd0);
        if_req = 1'b0;
        @(negedge clk);
        chk("both.if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("both.if_rdata",  if_rdata,           32'h00A0_8023);
        chk("both.d_ack_off", {31'd0, d_ack},     32'd0);
        @(negedge clk);

        // Store 0x11 to 0x24 (word 9)
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'h11;
        @(negedge clk);
        chk("st.d_gnt",    {31'd0, d_gnt},  32'd1);
        chk("st.mem_we",   {31'd0, mem_we}, 32'd1);
        chk("st.mem_re",   {31'd0, mem_re}, 32'd0);
        chk("st.mem_addr", mem_addr,        32'd9);
        chk("st.mem_din",  mem_din,         32'h11);
        d_req = 1'b0;
        @(negedge clk);
        chk("st.d_ack",   {31'd0, d_ack},  32'd1);
        chk("st.d_rdata", d_rdata,         32'd0);
        chk("st.d_err",   {31'd0, d_err},  32'd0);
        chk("st.we_once", {31'd0, mem_we}, 32'd0);
        @(negedge clk);

        // Load back 0x24
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        chk("ld.d_ack",   {31'd0, d_ack}, 32'd1);
        chk("ld.d_rdata", d_rdata,        32'h11);
        @(negedge clk);

        // Misaligned store 0x26
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h26; d_wdata = 32'h55;
        @(negedge clk);
        chk("mis.d_gnt",  {31'd0, d_gnt},  32'd1);
        chk("mis.mem_we", {31'd0, mem_we}, 32'd0);
        chk("mis.mem_re", {31'd0, mem_re}, 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        chk("mis.d_ack",   {31'd0, d_ack}, 32'd1);
        chk("mis.d_err",   {31'd0, d_err}, 32'd1);
        chk("mis.d_rdata", d_rdata,        32'd0);
        chk("mis.mem9",    mem[9],         32'h11);
        @(negedge clk);

        // Out-of-range load 0x400 (word 256)
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        @(negedge clk);
        chk("oor.mem_we", {31'd0, mem_we}, 32'd0);
        chk("oor.mem_re", {31'd0, mem_re}, 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        chk("oor.d_ack",   {31'd0, d_ack}, 32'd1);
        chk("oor.d_err",   {31'd0, d_err}, 32'd1);
        chk("oor.d_rdata", d_rdata,        32'd0);
        @(negedge clk);

        // Contention: both held for 10 cycles, expect D,I,D,I...
        if_req = 1'b1; if_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0C;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("alt%0d.d_gnt", i),  {31'd0, d_gnt},  (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("alt%0d.if_gnt", i), {31'd0, if_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("alt.idle.d_gnt",  {31'd0, d_gnt},  32'd0);
        chk("alt.idle.if_gnt", {31'd0, if_gnt}, 32'd0);
        @(negedge clk);

        // Reset pulsed mid-store to 0x30 (word 12)
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFE;
        @(negedge clk);
        chk("rst.pre_we", {31'd0, mem_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1 all_zero("rst");
        @(posedge clk);
        d_req = 1'b0;
        @(negedge clk);
        chk("rst.mem12", mem[12], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.idle.d_gnt",  {31'd0, d_gnt},  32'd0);
        chk("rst.idle.if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("rst.mem12_after", mem[12],         32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
